axi_regbank: RTL and testbench
==============================

AXI_REGBANK -- requirements
Module: axi_regbank

Interface
REQ-001 The module SHALL expose parameter ADDR_W, default 16, AXI address width in bits (min 4).
REQ-002 The module SHALL expose parameter N_RW, default 8, number of 32-bit read/write control registers (1..64).
REQ-003 The module SHALL expose parameter N_RO, default 8, number of 32-bit read-only status registers (1..64).
REQ-004 The module SHALL expose parameter RW_RST_VAL, default 32'h0, reset value of every control register.
REQ-005 axi_clk  in  1  single clock for all logic; no other clock SHALL exist.
REQ-006 axi_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 AXI4-Lite slave ports SHALL be: axi_awaddr in ADDR_W, axi_awprot in 3, axi_awvalid in 1, axi_awready out 1, axi_wdata in 32, axi_wstrb in 4, axi_wvalid in 1, axi_wready out 1, axi_bresp out 2, axi_bvalid out 1, axi_bready in 1, axi_araddr in ADDR_W, axi_arprot in 3, axi_arvalid in 1, axi_arready out 1, axi_rdata out 32, axi_rresp out 2, axi_rvalid out 1, axi_rready in 1.
REQ-008 ctrl_q  out  32*N_RW  flattened control registers, register k at bits [32k+31:32k].
REQ-009 ctrl_wr_pulse  out  N_RW  one-cycle strobe per control register on update.
REQ-010 stat_d  in  32*N_RO  flattened status inputs, same packing as ctrl_q, sampled directly (same clock domain).
REQ-011 stat_rd_pulse  out  N_RO  one-cycle strobe per status register on read (for clear-on-read logic outside).

Function
REQ-012 Word index SHALL be addr[ADDR_W-1:2]; addr[1:0] and axi_*prot SHALL be ignored.
REQ-013 Index 0..N_RW-1 SHALL map to control regs; N_RW..N_RW+N_RO-1 to status regs; all higher indices unmapped.
REQ-014 Write FSM states SHALL be W_IDLE, W_WAIT, W_RESP; AW and W channels accepted independently, either order.
REQ-015 In W_IDLE/W_WAIT axi_awready SHALL be 1 until AW captured and axi_wready 1 until W captured, then 0 until return to W_IDLE.
REQ-016 On the edge after both AW and W are captured (same-cycle capture included: latency 1), the FSM SHALL enter W_RESP, assert axi_bvalid, and apply the write.
REQ-017 Control write SHALL update only bytes with axi_wstrb[b]=1; wstrb=0 SHALL be a legal no-op returning OKAY; ctrl_wr_pulse[k] SHALL assert for exactly that cycle regardless of strobes.
REQ-018 Writes to status or unmapped indices SHALL change no state, pulse nothing, and return bresp=2'b10 (SLVERR); control writes return 2'b00.
REQ-019 axi_bvalid and axi_bresp SHALL hold until axi_bready=1; on that edge FSM returns to W_IDLE, readies reassert the following cycle.
REQ-020 Read FSM states SHALL be R_IDLE, R_DATA; axi_arready=1 only in R_IDLE.
REQ-021 On AR handshake edge+1 the FSM SHALL enter R_DATA with axi_rvalid=1, axi_rdata=register value sampled at the handshake cycle, rresp 2'b00 mapped / 2'b10 unmapped with rdata 0.
REQ-022 stat_rd_pulse[j] SHALL assert for one cycle, coincident with axi_rvalid rising, for status reads only.
REQ-023 axi_rdata/axi_rresp SHALL stay stable while axi_rvalid=1 and axi_rready=0; on rready edge FSM returns to R_IDLE.
REQ-024 Read and write FSMs SHALL be independent; a read sampling a control reg in the same cycle its write is applied SHALL return the pre-write value.
REQ-025 At most one outstanding transaction per direction; no further AW/W/AR SHALL be accepted until its response completes.

Reset
REQ-026 While axi_rst_n=0: ctrl_q=RW_RST_VAL per reg, all pulses 0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, awready=wready=arready=0, FSMs in idle.
REQ-027 Readies SHALL assert the first cycle after reset release; reset mid-transaction SHALL abort it with no register update and no response.

Verification
REQ-028 AW and W same cycle, idx 2, data 32'hDEADBEEF, wstrb F -> bvalid next cycle, bresp 00, ctrl_q reg2=DEADBEEF, ctrl_wr_pulse=8'h04 one cycle.
REQ-029 W three cycles before AW, idx 1, data 32'h11223344, wstrb 4'b0101 over RW_RST_VAL 0 -> reg1=32'h00220044, bresp 00.
REQ-030 Write idx 9 (status) and idx 40 (unmapped) -> bresp 10 each, ctrl_q unchanged, no pulses.
REQ-031 stat_d reg3=32'hCAFE0003, read idx 11 with rready held low 5 cycles -> rdata CAFE0003 stable, rresp 00, stat_rd_pulse=8'h08 exactly once; read idx 20 -> rdata 0, rresp 10.
REQ-032 Write idx 0 = 32'h5 and read idx 0 applied same cycle -> read returns old value 0, next read returns 5.
REQ-033 Drop axi_rst_n with bvalid pending -> bvalid 0 immediately, ctrl_q back to RW_RST_VAL, readies 1 cycle after release.

Source files
------------

// File: rtl/axi_regbank.sv
// AXI4-Lite slave register bank: N_RW byte-writable control registers followed by
// N_RO read-only status registers, with per-register write and read strobes.
module axi_regbank #(
    parameter int          ADDR_W     = 16,
    parameter int          N_RW       = 8,
    parameter int          N_RO       = 8,
    parameter logic [31:0] RW_RST_VAL = 32'h0
) (
    input  logic                axi_clk,
    input  logic                axi_rst_n,
    input  logic [ADDR_W-1:0]   axi_awaddr,
    input  logic [2:0]          axi_awprot,
    input  logic                axi_awvalid,
    output logic                axi_awready,
    input  logic [31:0]         axi_wdata,
    input  logic [3:0]          axi_wstrb,
    input  logic                axi_wvalid,
    output logic                axi_wready,
    output logic [1:0]          axi_bresp,
    output logic                axi_bvalid,
    input  logic                axi_bready,
    input  logic [ADDR_W-1:0]   axi_araddr,
    input  logic [2:0]          axi_arprot,
    input  logic                axi_arvalid,
    output logic                axi_arready,
    output logic [31:0]         axi_rdata,
    output logic [1:0]          axi_rresp,
    output logic                axi_rvalid,
    input  logic                axi_rready,
    output logic [32*N_RW-1:0]  ctrl_q,
    output logic [N_RW-1:0]     ctrl_wr_pulse,
    input  logic [32*N_RO-1:0]  stat_d,
    output logic [N_RO-1:0]     stat_rd_pulse
);

    localparam int         IDX_W     = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLV  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic [31:0] word_idx(input logic [IDX_W-1:0] idx);
        return 32'(idx);
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    w_state_t          w_state, w_state_nxt;
    r_state_t          r_state, r_state_nxt;
    logic              rdy_en;
    logic              aw_got, w_got;
    logic              aw_hs, w_hs, ar_hs, w_fire;
    logic [IDX_W-1:0]  awidx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       w_idx, r_idx;
    logic [31:0]       w_data_eff;
    logic [3:0]        w_strb_eff;
    logic              w_is_ctrl, r_mapped;
    logic [31:0]       r_data_c;
    logic [N_RO-1:0]   r_stat_c;
    logic              unused_ok;

    assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

    // Readies stay low in reset and during the first cycle out of it.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) rdy_en <= 1'b0;
        else            rdy_en <= 1'b1;
    end

    assign axi_awready = rdy_en && (w_state != W_RESP) && !aw_got;
    assign axi_wready  = rdy_en && (w_state != W_RESP) && !w_got;
    assign axi_bvalid  = (w_state == W_RESP);
    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;
    assign w_fire      = (aw_got || aw_hs) && (w_got || w_hs);

    // Either beat may arrive live on the completing cycle, so mux captured vs. bus.
    assign w_idx      = word_idx(aw_got ? awidx_q : axi_awaddr[ADDR_W-1:2]);
    assign w_data_eff = w_got ? wdata_q : axi_wdata;
    assign w_strb_eff = w_got ? wstrb_q : axi_wstrb;
    assign w_is_ctrl  = (w_idx < 32'(N_RW));

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            w_state <= W_IDLE;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (w_fire) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE, W_WAIT: begin
                if (w_fire)              w_state_nxt = W_RESP;
                else if (aw_hs || w_hs)  w_state_nxt = W_WAIT;
            end
            W_RESP:  if (axi_bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (aw_hs) awidx_q <= axi_awaddr[ADDR_W-1:2];
        if (w_hs) begin
            wdata_q <= axi_wdata;
            wstrb_q <= axi_wstrb;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            ctrl_q        <= {N_RW{RW_RST_VAL}};
            ctrl_wr_pulse <= '0;
            axi_bresp     <= RESP_OKAY;
        end else begin
            ctrl_wr_pulse <= '0;
            if (w_fire) begin
                axi_bresp <= w_is_ctrl ? RESP_OKAY : RESP_SLV;
                for (int k = 0; k < N_RW; k++) begin
                    if (w_idx == 32'(k)) begin
                        ctrl_q[32*k +: 32] <= apply_strb(ctrl_q[32*k +: 32], w_data_eff, w_strb_eff);
                        ctrl_wr_pulse[k]   <= 1'b1;
                    end
                end
            end
        end
    end

    assign axi_arready = rdy_en && (r_state == R_IDLE);
    assign axi_rvalid  = (r_state == R_DATA);
    assign ar_hs       = axi_arvalid && axi_arready;
    assign r_idx       = word_idx(axi_araddr[ADDR_W-1:2]);
    assign r_mapped    = (r_idx < 32'(N_RW + N_RO));

    // Unmapped indices fall through with zero data.
    always_comb begin
        r_data_c = '0;
        r_stat_c = '0;
        for (int k = 0; k < N_RW; k++) begin
            if (r_idx == 32'(k)) r_data_c = ctrl_q[32*k +: 32];
        end
        for (int j = 0; j < N_RO; j++) begin
            if (r_idx == 32'(N_RW + j)) begin
                r_data_c    = stat_d[32*j +: 32];
                r_stat_c[j] = 1'b1;
            end
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)      r_state_nxt = R_DATA;
            R_DATA:  if (axi_rready) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            r_state       <= R_IDLE;
            axi_rdata     <= '0;
            axi_rresp     <= RESP_OKAY;
            stat_rd_pulse <= '0;
        end else begin
            r_state       <= r_state_nxt;
            stat_rd_pulse <= '0;
            if (ar_hs) begin
                axi_rdata     <= r_data_c;
                axi_rresp     <= r_mapped ? RESP_OKAY : RESP_SLV;
                stat_rd_pulse <= r_stat_c;
            end
        end
    end

endmodule

// File: tb/tb_axi_regbank.sv
// Directed bench for axi_regbank with default parameters (8 control, 8 status regs).
module tb_axi_regbank;

    logic         axi_clk = 1'b0;
    logic         axi_rst_n;
    logic [15:0]  axi_awaddr;
    logic [2:0]   axi_awprot;
    logic         axi_awvalid;
    logic         axi_awready;
    logic [31:0]  axi_wdata;
    logic [3:0]   axi_wstrb;
    logic         axi_wvalid;
    logic         axi_wready;
    logic [1:0]   axi_bresp;
    logic         axi_bvalid;
    logic         axi_bready;
    logic [15:0]  axi_araddr;
    logic [2:0]   axi_arprot;
    logic         axi_arvalid;
    logic         axi_arready;
    logic [31:0]  axi_rdata;
    logic [1:0]   axi_rresp;
    logic         axi_rvalid;
    logic         axi_rready;
    logic [255:0] ctrl_q;
    logic [7:0]   ctrl_wr_pulse;
    logic [255:0] stat_d;
    logic [7:0]   stat_rd_pulse;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int spulse_cnt = 0;
    logic [255:0] exp_ctrl;

    always #5 axi_clk = ~axi_clk;

    axi_regbank dut (
        .axi_clk(axi_clk), .axi_rst_n(axi_rst_n),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_araddr(axi_araddr),
        .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready), .ctrl_q(ctrl_q), .ctrl_wr_pulse(ctrl_wr_pulse),
        .stat_d(stat_d), .stat_rd_pulse(stat_rd_pulse)
    );

    always @(negedge axi_clk) begin
        if (stat_rd_pulse != 8'h00) spulse_cnt++;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int lead, input logic [1:0] exp_resp, input logic [7:0] exp_pulse,
                      input logic [255:0] exp_c, input string tag);
        axi_awaddr = addr;
        axi_wdata  = data;
        axi_wstrb  = strb;
        axi_wvalid = 1'b1;
        if (lead > 0) begin
            tick();
            axi_wvalid = 1'b0;
            repeat (lead - 1) tick();
            check({tag, "_wait"}, {axi_awready, axi_wready, axi_bvalid}, 3'b100);
        end
        axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        check({tag, "_resp"}, {axi_bvalid, axi_bresp, ctrl_wr_pulse}, {1'b1, exp_resp, exp_pulse});
        check({tag, "_ctrl"}, ctrl_q, exp_c);
        tick();
        check({tag, "_hold"}, {axi_bvalid, axi_bresp, ctrl_wr_pulse, axi_awready, axi_wready},
              {1'b1, exp_resp, 8'h00, 2'b00});
        axi_bready = 1'b1;
        tick();
        axi_bready = 1'b0;
        check({tag, "_done"}, {axi_bvalid, axi_awready, axi_wready}, 3'b011);
    endtask

    task automatic rd(input logic [15:0] addr, input int hold, input logic [31:0] exp_data,
                      input logic [1:0] exp_resp, input logic [7:0] exp_sp, input string tag);
        int c0;
        c0 = spulse_cnt;
        axi_araddr  = addr;
        axi_arvalid = 1'b1;
        tick();
        axi_arvalid = 1'b0;
        check({tag, "_data"}, {axi_rvalid, axi_rresp, axi_rdata, stat_rd_pulse},
              {1'b1, exp_resp, exp_data, exp_sp});
        if (hold > 0) begin
            repeat (hold) tick();
            check({tag, "_stable"}, {axi_rvalid, axi_rresp, axi_rdata, stat_rd_pulse, axi_arready},
                  {1'b1, exp_resp, exp_data, 8'h00, 1'b0});
        end
        axi_rready = 1'b1;
        tick();
        axi_rready = 1'b0;
        check({tag, "_done"}, {axi_rvalid, axi_arready}, 2'b01);
        check({tag, "_spcnt"}, 32'(spulse_cnt - c0), (exp_sp != 8'h00) ? 32'd1 : 32'd0);
    endtask

    initial begin
        axi_rst_n   = 1'b0;
        axi_awaddr  = '0;
        axi_awprot  = 3'b010;
        axi_awvalid = 1'b0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        axi_araddr  = '0;
        axi_arprot  = 3'b101;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        stat_d      = '0;
        stat_d[3*32 +: 32] = 32'hCAFE0003;
        stat_d[0 +: 32]    = 32'h0BAD0000;
        exp_ctrl    = '0;

        repeat (2) tick();
        check("rst_readies", {axi_awready, axi_wready, axi_arready}, 3'b000);
        check("rst_resp", {axi_bvalid, axi_rvalid, axi_bresp, axi_rresp, axi_rdata}, '0);
        check("rst_ctrl", ctrl_q, '0);
        check("rst_pulses", {ctrl_wr_pulse, stat_rd_pulse}, '0);

        axi_rst_n = 1'b1;
        check("release_same_cycle", {axi_awready, axi_wready, axi_arready}, 3'b000);
        tick();
        check("release_next_cycle", {axi_awready, axi_wready, axi_arready}, 3'b111);

        exp_ctrl[2*32 +: 32] = 32'hDEADBEEF;
        wr(16'h0008, 32'hDEADBEEF, 4'hF, 0, 2'b00, 8'h04, exp_ctrl, "same_cycle_idx2");

        exp_ctrl[1*32 +: 32] = 32'h00220044;
        wr(16'h0004, 32'h11223344, 4'b0101, 3, 2'b00, 8'h02, exp_ctrl, "w_first_idx1");

        wr(16'h0008, 32'hFFFFFFFF, 4'h0, 1, 2'b00, 8'h04, exp_ctrl, "strb0_noop");
        wr(16'h0024, 32'h12345678, 4'hF, 0, 2'b10, 8'h00, exp_ctrl, "status_idx9");
        wr(16'h00A0, 32'h87654321, 4'hF, 2, 2'b10, 8'h00, exp_ctrl, "unmapped_idx40");

        rd(16'h002C, 5, 32'hCAFE0003, 2'b00, 8'h08, "stat_idx11");
        rd(16'h0050, 0, 32'h00000000, 2'b10, 8'h00, "unmapped_idx20");
        rd(16'h0007, 0, 32'h00220044, 2'b00, 8'h00, "ctrl_idx1_lowbits");
        rd(16'h0008, 0, 32'hDEADBEEF, 2'b00, 8'h00, "ctrl_idx2");
        rd(16'h0020, 0, 32'h0BAD0000, 2'b00, 8'h01, "stat_idx8");

        // Write and read of reg 0 complete on the same edge.
        axi_awaddr  = 16'h0000;
        axi_wdata   = 32'h00000005;
        axi_wstrb   = 4'hF;
        axi_araddr  = 16'h0000;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        axi_arvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_arvalid = 1'b0;
        exp_ctrl[0 +: 32] = 32'h00000005;
        check("rw_same_read_old", {axi_rvalid, axi_rresp, axi_rdata}, {1'b1, 2'b00, 32'h0});
        check("rw_same_write", {axi_bvalid, axi_bresp, ctrl_wr_pulse}, {1'b1, 2'b00, 8'h01});
        check("rw_same_ctrl", ctrl_q, exp_ctrl);
        axi_bready = 1'b1;
        axi_rready = 1'b1;
        tick();
        axi_bready = 1'b0;
        axi_rready = 1'b0;
        rd(16'h0000, 0, 32'h00000005, 2'b00, 8'h00, "rw_same_reread");

        // Reset while a write response is pending.
        axi_awaddr  = 16'h000C;
        axi_wdata   = 32'h00000077;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        check("pre_reset_bvalid", axi_bvalid, 1'b1);
        #2;
        axi_rst_n = 1'b0;
        #1;
        check("async_rst_bvalid", {axi_bvalid, axi_rvalid, axi_bresp}, '0);
        check("async_rst_ctrl", ctrl_q, '0);
        check("async_rst_readies", {axi_awready, axi_wready, axi_arready}, 3'b000);
        tick();
        axi_rst_n = 1'b1;
        check("rerelease_same_cycle", {axi_awready, axi_wready, axi_arready}, 3'b000);
        tick();
        check("rerelease_next_cycle", {axi_awready, axi_wready, axi_arready, axi_bvalid}, 4'b1110);
        rd(16'h000C, 0, 32'h00000000, 2'b00, 8'h00, "aborted_idx3");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
